// File: rtl/seg595_pkg.sv
// Shared constants and types for the 74HC595 seven-segment scan controller.
package seg595_pkg;

  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } scan_state_e;

  // Active-low segment codes, entry 0 in the low byte through entry F in the high byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg595_shifter.sv
// 16-bit MSB-first serializer producing sclk/dio for a 74HC595 chain.
// A start pulse loads the word; done is high in the last cycle of the final sclk high phase.
module seg595_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data,
  output logic        sclk,
  output logic        dio,
  output logic        done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_LAST = div_t'(CLK_DIV - 1);

  logic [15:0] word_q;
  logic [3:0]  bit_q;
  div_t        div_q;
  logic        high_q;
  logic        busy_q;
  logic        sclk_q;
  logic        dio_q;
  logic        phase_end;

  assign phase_end = busy_q && (div_q == DIV_LAST);
  assign done      = phase_end && high_q && (bit_q == 4'd15);
  assign sclk      = sclk_q;
  assign dio       = dio_q;

  // dio only moves together with a falling sclk, giving CLK_DIV cycles of setup and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      bit_q  <= '0;
      div_q  <= '0;
      high_q <= 1'b0;
      busy_q <= 1'b0;
      sclk_q <= 1'b1;
      dio_q  <= 1'b0;
    end else if (start) begin
      word_q <= data;
      bit_q  <= '0;
      div_q  <= '0;
      high_q <= 1'b0;
      busy_q <= 1'b1;
      sclk_q <= 1'b0;
      dio_q  <= data[15];
    end else if (busy_q) begin
      if (!phase_end) begin
        div_q <= div_q + div_t'(1);
      end else begin
        div_q <= '0;
        if (!high_q) begin
          high_q <= 1'b1;
          sclk_q <= 1'b1;
        end else if (bit_q == 4'd15) begin
          high_q <= 1'b0;
          busy_q <= 1'b0;
        end else begin
          high_q <= 1'b0;
          sclk_q <= 1'b0;
          word_q <= word_q << 1;
          dio_q  <= word_q[14];
          bit_q  <= bit_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/seg595_scan_ctrl.sv
// Four-digit scan controller for a two-stage 74HC595 chain with double-buffered digits.
// Optional build macro SEG595_LZB_EN enables leading-zero blanking.
module seg595_scan_ctrl
  import seg595_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int SCAN_HOLD = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic       sclk,
  output logic       rclk,
  output logic       dio,
  output logic       frame_done,
  output logic       commit_pend
);

  localparam int CNT_MAX = (SCAN_HOLD > CLK_DIV) ? SCAN_HOLD : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_DIV  = cnt_t'(CLK_DIV - 1);
  localparam cnt_t LAST_HOLD = cnt_t'(SCAN_HOLD - 1);

  scan_state_e state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        start;
  logic        shift_done;
  logic        frame_end;
  logic        rclk_q;
  logic        commit_pend_q;

  logic [DIGITS-1:0][3:0] shadow_q;
  logic [DIGITS-1:0][3:0] shadow_fwd;
  logic [DIGITS-1:0][3:0] active_q;

  logic [3:0]  digit_val;
  logic        blank;
  logic [7:0]  seg_byte;
  logic [7:0]  sel_byte;
  logic [15:0] word;

  assign digit_val = active_q[idx_q];

`ifdef SEG595_LZB_EN
  // Blank when this digit and every more-significant digit are zero; digit 0 always shows.
  assign blank = (idx_q != 2'd0) && ((active_q >> {idx_q, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  assign seg_byte = blank ? 8'hFF : SEG_TABLE[digit_val];
  assign sel_byte = 8'hF0 | (8'd1 << idx_q);
  assign word     = {seg_byte, sel_byte};

  seg595_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (word),
    .sclk  (sclk),
    .dio   (dio),
    .done  (shift_done)
  );

  // A write landing in the frame boundary cycle must reach the active copy.
  always_comb begin
    shadow_fwd = shadow_q;
    if (wr_en) shadow_fwd[wr_addr] = wr_data;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    start     = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      LOAD: begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_done) begin
          cnt_d   = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (cnt_q == LAST_DIV) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      HOLD: begin
        if (cnt_q == LAST_HOLD) begin
          cnt_d   = '0;
          state_d = LOAD;
          if (idx_q == 2'd0) begin
            frame_end = 1'b1;
            idx_d     = 2'd3;
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // rclk is registered from the next state so it is low exactly for the LATCH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      rclk_q        <= 1'b1;
      commit_pend_q <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rclk_q  <= (state_d != LATCH);
      if (wr_en) shadow_q[wr_addr] <= wr_data;
      if (frame_end && (commit_pend_q || commit)) active_q <= shadow_fwd;
      if (frame_end) begin
        commit_pend_q <= 1'b0;
      end else if (commit) begin
        commit_pend_q <= 1'b1;
      end
    end
  end

  assign rclk        = rclk_q;
  assign frame_done  = frame_end;
  assign commit_pend = commit_pend_q;

endmodule

// File: tb/tb_seg595_scan_ctrl.sv
// Directed self-checking bench for seg595_scan_ctrl; decodes the serial stream into 16-bit words.
module tb_seg595_scan_ctrl;

  localparam int CLK_DIV      = 2;
  localparam int SCAN_HOLD    = 20;
  localparam int DIGIT_PERIOD = 1 + 33 * CLK_DIV + SCAN_HOLD;
  localparam int FRAME_PERIOD = 4 * DIGIT_PERIOD;

`ifdef SEG595_LZB_EN
  localparam logic [7:0] ZERO_LEAD = 8'hFF;
`else
  localparam logic [7:0] ZERO_LEAD = 8'hC0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       commit = 1'b0;
  logic       sclk, rclk, dio, frame_done, commit_pend;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int bit_cnt = 0;
  int bad_latch = 0;
  int rclk_overlap = 0;
  int rel_cyc, fd_cyc;
  logic [15:0] sh = '0;
  logic [15:0] words[$];
  logic prev_sclk = 1'b1;
  logic prev_rclk = 1'b1;

  seg595_scan_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .SCAN_HOLD (SCAN_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .sclk        (sclk),
    .rclk        (rclk),
    .dio         (dio),
    .frame_done  (frame_done),
    .commit_pend (commit_pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behaves like the 595 pair: sample dio on sclk rise, capture the word on rclk rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      bit_cnt = 0;
      sh = '0;
    end else begin
      if (sclk && !prev_sclk) begin
        sh = {sh[14:0], dio};
        bit_cnt++;
      end
      if (rclk && !prev_rclk) begin
        if (bit_cnt != 16) bad_latch++;
        words.push_back(sh);
        bit_cnt = 0;
      end
      if (!rclk && !sclk) rclk_overlap++;
    end
    prev_sclk = sclk;
    prev_rclk = rclk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [3:0] data,
                               input logic cm);
    wr_en   = we;
    wr_addr = addr;
    wr_data = data;
    commit  = cm;
    @(negedge clk);
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic waitFrameDone(input string tag);
    int n;
    @(negedge clk);
    n = 1;
    while (frame_done !== 1'b1 && n < 2 * FRAME_PERIOD) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_fd_seen"}, 16'(frame_done), 16'd1);
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] e3, input logic [15:0] e2,
                            input logic [15:0] e1, input logic [15:0] e0);
    logic [15:0] exp_w[4];
    exp_w = '{e3, e2, e1, e0};
    checkOutput({tag, "_count"}, 16'(words.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_word%0d", tag, i), (words.size() > i) ? words[i] : 16'hXXXX,
                  exp_w[i]);
    end
    words.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_sclk", 16'(sclk), 16'd1);
    checkOutput("rst_rclk", 16'(rclk), 16'd1);
    checkOutput("rst_dio", 16'(dio), 16'd0);
    checkOutput("rst_frame_done", 16'(frame_done), 16'd0);
    checkOutput("rst_commit_pend", 16'(commit_pend), 16'd0);

    rst_n = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    checkOutput("first_sclk_fall", 16'(sclk), 16'd0);
    checkOutput("first_dio", 16'(dio), 16'd1);

    waitFrameDone("f0");
    fd_cyc = cyc;
    checkOutput("f0_latency", 16'(fd_cyc - rel_cyc), 16'(FRAME_PERIOD - 1));
    checkFrame("f0", {ZERO_LEAD, 8'hF8}, {ZERO_LEAD, 8'hF4}, {ZERO_LEAD, 8'hF2}, 16'hC0F1);

    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 2'd3, 4'd1, 1'b0);
    applyStimulus(1'b1, 2'd2, 4'd2, 1'b0);
    applyStimulus(1'b1, 2'd1, 4'd3, 1'b0);
    applyStimulus(1'b1, 2'd0, 4'd4, 1'b0);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("pend_after_commit", 16'(commit_pend), 16'd1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    checkOutput("pend_absorbed", 16'(commit_pend), 16'd1);

    waitFrameDone("f1");
    checkOutput("f1_period", 16'(cyc - fd_cyc), 16'(FRAME_PERIOD));
    checkOutput("pend_at_fd", 16'(commit_pend), 16'd1);
    checkFrame("f1", {ZERO_LEAD, 8'hF8}, {ZERO_LEAD, 8'hF4}, {ZERO_LEAD, 8'hF2}, 16'hC0F1);
    @(negedge clk);
    checkOutput("pend_clear_after_fd", 16'(commit_pend), 16'd0);

    applyStimulus(1'b1, 2'd0, 4'hF, 1'b0);
    waitFrameDone("f2");
    checkFrame("f2", 16'hF9F8, 16'hA4F4, 16'hB0F2, 16'h99F1);
    checkOutput("f2_no_pend", 16'(commit_pend), 16'd0);
    waitFrameDone("f3");
    checkFrame("f3", 16'hF9F8, 16'hA4F4, 16'hB0F2, 16'h99F1);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b1);
    waitFrameDone("f4");
    checkFrame("f4", 16'hF9F8, 16'hA4F4, 16'hB0F2, 16'h99F1);

    waitFrameDone("f5");
    checkFrame("f5", 16'hF9F8, 16'hA4F4, 16'hB0F2, 16'h8EF1);
    applyStimulus(1'b1, 2'd2, 4'd7, 1'b1);
    checkOutput("pend_fd_commit", 16'(commit_pend), 16'd0);

    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 2'd3, 4'd0, 1'b0);
    applyStimulus(1'b1, 2'd2, 4'd0, 1'b0);
    applyStimulus(1'b1, 2'd1, 4'd4, 1'b0);
    applyStimulus(1'b1, 2'd0, 4'd0, 1'b1);
    waitFrameDone("f6");
    checkFrame("f6", 16'hF9F8, 16'hF8F4, 16'hB0F2, 16'h8EF1);
    waitFrameDone("f7");
    checkFrame("f7", {ZERO_LEAD, 8'hF8}, {ZERO_LEAD, 8'hF4}, 16'h99F2, 16'hC0F1);

    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(bit_cnt == 9 && sclk == 1'b0) && n < 2 * DIGIT_PERIOD);
    checkOutput("mid_shift_reached", 16'(bit_cnt), 16'd9);
    checkOutput("mid_shift_dio", 16'(dio), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_sclk", 16'(sclk), 16'd1);
    checkOutput("async_rclk", 16'(rclk), 16'd1);
    checkOutput("async_dio", 16'(dio), 16'd0);
    checkOutput("async_commit_pend", 16'(commit_pend), 16'd0);
    repeat (4) @(negedge clk);
    checkOutput("no_partial_latch", 16'(words.size()), 16'd0);
    rst_n = 1'b1;
    n = 0;
    while (words.size() == 0 && n < 2 * DIGIT_PERIOD) begin
      @(negedge clk);
      n++;
    end
    checkOutput("restart_count", 16'(words.size()), 16'd1);
    checkOutput("restart_word", (words.size() > 0) ? words[0] : 16'hXXXX, {ZERO_LEAD, 8'hF8});

    checkOutput("latch_bit_count", 16'(bad_latch), 16'd0);
    checkOutput("rclk_during_shift", 16'(rclk_overlap), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg595_scan_ctrl.md
# seg595_scan_ctrl

Scan controller for the 4-digit 7-segment display behind a two-stage 74HC595 shift chain. It owns a double-buffered 4×4-bit digit store that the UART command path writes into. It sequences the serial segment-byte and digit-select-byte shifts, the latch pulse and the per-digit hold from the system clock; no derived clocks are used. It sits between the UART receive/command logic and the SCLK/RCLK/DIO board pins.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period and per RCLK low phase; legal range ≥1.
- `SCAN_HOLD`, default 3000: clocks each digit stays latched before the next digit loads; legal range ≥1.
- `clk  in  1`: system clock, 12 MHz.
- `rst_n  in  1`: one clock; reset is asynchronous and active-low.
- `wr_en  in  1`: write strobe into the shadow buffer.
- `wr_addr  in  2`: digit index; 0 = units, 3 = thousands.
- `wr_data  in  4`: digit value 0–15, displayed as hex.
- `commit  in  1`: single-cycle request to copy shadow to active at the next frame boundary.
- `sclk  out  1`: shift clock; data is sampled by the 595 on the rising edge.
- `rclk  out  1`: storage latch; outputs update on the rising edge.
- `dio  out  1`: serial data, MSB first.
- `frame_done  out  1`: one-cycle pulse after digit 0 hold completes.
- `commit_pend  out  1`: high from commit accepted until the copy is applied.

## Operation
- Reset values: `sclk`=1, `rclk`=1, `dio`=0, `frame_done`=0, `commit_pend`=0, shadow=active=0, state=LOAD, digit index=3.
- Scan order is 3,2,1,0, then repeat.
- Per digit, the shifted word is 16 bits: `{seg_byte, sel_byte}`.
  - `seg_byte` = active-low segment code from a 16-entry table (0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E).
  - `sel_byte` = 8'hF0 | (1<<idx).
- FSM states:
  - LOAD (1 cycle): capture the 16-bit word, bit counter = 0, go to SHIFT.
  - SHIFT: per bit, `sclk`=0 and `dio`=word[15] for CLK_DIV cycles, then `sclk`=1 for CLK_DIV cycles, then shift the word left. After 16 bits go to LATCH.
  - LATCH: `rclk`=0 for CLK_DIV cycles, then `rclk`=1, go to HOLD.
  - HOLD: count SCAN_HOLD cycles. Then, if idx==0, pulse `frame_done`, apply any pending commit, and set idx=3; otherwise idx−1. Go to LOAD.
- Writes: `wr_en` updates `shadow[wr_addr]` on the same edge. Writes are accepted in every state and never affect the digit being shifted.
- Commit:
  - `commit` sets `commit_pend`. The copy shadow→active occurs on the `frame_done` cycle; `commit_pend` clears on that same edge.
  - Repeated commits while pending are absorbed.
  - A commit in the `frame_done` cycle itself is applied at that boundary.
  - A `wr_en` in the `frame_done` cycle is included in the copy, because the shadow value is forwarded.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously); no partial latch is issued.

## Timing
- First `sclk` falling edge occurs 1 cycle after `rst_n` deasserts (LOAD cycle).
- Digit period = 1 + 32·CLK_DIV + CLK_DIV + SCAN_HOLD cycles. With defaults: 1+128+4+3000 = 3133 cycles.
- Frame period = 4 × digit period = 12532 cycles (≈958 Hz at 12 MHz).
- `dio` changes only while `sclk` is low. Setup and hold to the rising `sclk` edge are each CLK_DIV cycles.
- `rclk` is never low while a shift is in progress.
- Commit-to-display latency is at most one frame plus one digit period.

## Configuration
- `SEG595_LZB_EN`: leading-zero blanking.
  - Defined: while scanning digit 3, 2 or 1, if that digit and all more-significant active digits are 0, `seg_byte`=8'hFF (blank). Digit 0 is never blanked.
  - Undefined: all four digits are always shown, so 0 displays as "0000".
  - Timing is identical in both builds.

## Structure
- Package `seg595_pkg` holds:
  - the segment code table constant;
  - the FSM state enum (LOAD, SHIFT, LATCH, HOLD);
  - the digit count constant (4).
- One sub-module, `seg595_shifter`: a 16-bit serializer with start/done handshake, parameterised by CLK_DIV, that generates `sclk`/`dio`.
- The scan FSM, buffers and commit logic stay in the top level.

## Test plan
- Reset, no writes, LZB off → four digit frames; the captured 16-bit words are C0F8, C0F4, C0F2, C0F1. `frame_done` pulses every 12532 cycles.
- Write shadow = {1,2,3,4} (addr3..0), commit mid-frame → the current frame still shows 0000; the next frame shifts F9F8, A4F4, B0F2, 99F1. `commit_pend` falls exactly at `frame_done`.
- Write addr0=0xF without commit for 3 frames → display unchanged; after a commit, the next frame shows 8E for digit 0.
- Assert `commit` and `wr_en`(addr2=7) in the `frame_done` cycle → the next frame's digit 2 word is F8F4 and `commit_pend` stays 0.
- Drop `rst_n` at bit 9 of a shift → `sclk`/`rclk`=1 and `dio`=0 at once. No `rclk` low pulse occurs; after release, the sequence restarts with the digit 3 LOAD.
- Build with `SEG595_LZB_EN`, active = {0,0,4,0} → words FFF8, FFF4, 99F2, C0F1.
